cdb_arbiter: RTL and testbench

Arbitrates completion results from NUM_FU functional units onto the single common data bus (CDB). The CDB marks ROB entries executed and wakes up PRF consumers. Each FU owns a one-entry holding slot with a valid/ready handshake. A registered round-robin arbiter broadcasts one result per cycle. The whole block flushes synchronously on mispredict recovery.

---
 rtl/cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU one-entry holding slots, registered broadcast.
// Define CDB_AGE_PRIO_EN for oldest-first (ROB age) selection instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int ROB_LEN = 5,
  parameter int PRF_LEN = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*ROB_LEN-1:0]   fu_rob_entry,
  input  logic [NUM_FU*PRF_LEN-1:0]   fu_dest_preg,
  input  logic [NUM_FU-1:0]           fu_mis_pred,
  input  logic                        squash,
`ifdef CDB_AGE_PRIO_EN
  input  logic [ROB_LEN-1:0]          rob_head,
`endif
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [ROB_LEN-1:0]          cdb_rob_entry,
  output logic [PRF_LEN-1:0]          cdb_dest_preg,
  output logic                        cdb_mis_pred,
  output logic [$clog2(NUM_FU)-1:0]   cdb_grant_idx
);

  localparam int IDX_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]  slot_valid_q, slot_valid_d;
  logic [ROB_LEN-1:0] slot_rob_q  [NUM_FU];
  logic [ROB_LEN-1:0] slot_rob_d  [NUM_FU];
  logic [PRF_LEN-1:0] slot_preg_q [NUM_FU];
  logic [PRF_LEN-1:0] slot_preg_d [NUM_FU];
  logic [NUM_FU-1:0]  slot_mis_q, slot_mis_d;

  logic               cdb_valid_q, cdb_valid_d;
  logic [ROB_LEN-1:0] cdb_rob_q, cdb_rob_d;
  logic [PRF_LEN-1:0] cdb_preg_q, cdb_preg_d;
  logic               cdb_mis_q, cdb_mis_d;
  logic [IDX_W-1:0]   cdb_idx_q, cdb_idx_d;

  logic [NUM_FU-1:0]  grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;

`ifdef CDB_AGE_PRIO_EN
  always_comb begin
    logic [ROB_LEN-1:0] age;
    logic [ROB_LEN-1:0] best;
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    age       = '0;
    best      = '0;
    // strict < keeps the lowest index on equal age
    for (int i = 0; i < NUM_FU; i++) begin
      age = slot_rob_q[i] - rob_head;
      if (slot_valid_q[i] && (!win_found || age < best)) begin
        win_found = 1'b1;
        best      = age;
        win_idx   = IDX_W'(i);
      end
    end
    if (win_found) grant[win_idx] = 1'b1;
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!win_found && slot_valid_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    if (win_found) grant[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!squash && win_found) rr_ptr_d = win_idx + IDX_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign fu_ready = {NUM_FU{~squash}} & (~slot_valid_q | grant);

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_rob_d   = slot_rob_q;
    slot_preg_d  = slot_preg_q;
    slot_mis_d   = slot_mis_q;
    cdb_valid_d  = 1'b0;
    cdb_rob_d    = cdb_rob_q;
    cdb_preg_d   = cdb_preg_q;
    cdb_mis_d    = cdb_mis_q;
    cdb_idx_d    = cdb_idx_q;
    if (squash) begin
      slot_valid_d = '0;
    end else begin
      // a granted slot may be refilled on the same edge
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i]) slot_valid_d[i] = 1'b0;
        if (fu_valid[i] && fu_ready[i]) begin
          slot_valid_d[i] = 1'b1;
          slot_rob_d[i]   = fu_rob_entry[i*ROB_LEN +: ROB_LEN];
          slot_preg_d[i]  = fu_dest_preg[i*PRF_LEN +: PRF_LEN];
          slot_mis_d[i]   = fu_mis_pred[i];
        end
      end
      if (win_found) begin
        cdb_valid_d = 1'b1;
        cdb_rob_d   = slot_rob_q[win_idx];
        cdb_preg_d  = slot_preg_q[win_idx];
        cdb_mis_d   = slot_mis_q[win_idx];
        cdb_idx_d   = win_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_preg_q   <= '0;
      cdb_mis_q    <= 1'b0;
      cdb_idx_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_preg_q   <= cdb_preg_d;
      cdb_mis_q    <= cdb_mis_d;
      cdb_idx_q    <= cdb_idx_d;
    end
  end

  // payload is qualified by slot_valid_q, so it needs no reset
  always_ff @(posedge clock) begin
    slot_rob_q  <= slot_rob_d;
    slot_preg_q <= slot_preg_d;
    slot_mis_q  <= slot_mis_d;
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_rob_entry = cdb_rob_q;
  assign cdb_dest_preg = cdb_preg_q;
  assign cdb_mis_pred  = cdb_mis_q;
  assign cdb_grant_idx = cdb_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Table-driven bench for cdb_arbiter: each row drives one cycle and queues the
// broadcast expected after that edge; the queue is drained after each edge.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  fu_valid;
  logic [19:0] fu_rob_entry;
  logic [23:0] fu_dest_preg;
  logic [3:0]  fu_mis_pred;
  logic        squash;
`ifdef CDB_AGE_PRIO_EN
  logic [4:0]  rob_head;
`endif
  logic [3:0]  fu_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_entry;
  logic [5:0]  cdb_dest_preg;
  logic        cdb_mis_pred;
  logic [1:0]  cdb_grant_idx;

  cdb_arbiter #(.NUM_FU(4), .ROB_LEN(5), .PRF_LEN(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_valid      (fu_valid),
    .fu_rob_entry  (fu_rob_entry),
    .fu_dest_preg  (fu_dest_preg),
    .fu_mis_pred   (fu_mis_pred),
    .squash        (squash),
`ifdef CDB_AGE_PRIO_EN
    .rob_head      (rob_head),
`endif
    .fu_ready      (fu_ready),
    .cdb_valid     (cdb_valid),
    .cdb_rob_entry (cdb_rob_entry),
    .cdb_dest_preg (cdb_dest_preg),
    .cdb_mis_pred  (cdb_mis_pred),
    .cdb_grant_idx (cdb_grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        sq;
    logic [3:0]  v;
    logic [19:0] rob;
    logic [23:0] preg;
    logic [3:0]  mis;
    logic [4:0]  head;
    logic [3:0]  rdy;
    logic        cv;
    logic [4:0]  crob;
    logic [5:0]  cpreg;
    logic        cmis;
    logic [1:0]  cidx;
  } vec_t;

  typedef struct {
    int         row;
    logic       rst;
    logic       cv;
    logic [4:0] crob;
    logic [5:0] cpreg;
    logic       cmis;
    logic [1:0] cidx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  logic [4:0] cur_head;
  int tests;
  int fails;

  task automatic add(input logic rst, input logic sq, input logic [3:0] v,
                     input logic [19:0] rob, input logic [23:0] preg,
                     input logic [3:0] mis, input logic [3:0] rdy,
                     input logic cv, input logic [4:0] crob,
                     input logic [5:0] cpreg, input logic cmis,
                     input logic [1:0] cidx);
    vec_t r;
    r.rst = rst; r.sq = sq; r.v = v; r.rob = rob; r.preg = preg;
    r.mis = mis; r.head = cur_head; r.rdy = rdy; r.cv = cv;
    r.crob = crob; r.cpreg = cpreg; r.cmis = cmis; r.cidx = cidx;
    tbl.push_back(r);
  endtask

  task automatic idle(input logic [3:0] rdy, input logic cv,
                      input logic [4:0] crob, input logic [5:0] cpreg,
                      input logic cmis, input logic [1:0] cidx);
    add(1'b0, 1'b0, 4'b0, 20'd0, 24'd0, 4'b0, rdy, cv, crob, cpreg, cmis, cidx);
  endtask

  task automatic rst_row(input logic sq);
    add(1'b1, sq, 4'b0, 20'd0, 24'd0, 4'b0, 4'b0, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic build_table();
    cur_head = 5'd0;
    rst_row(1'b0);
    rst_row(1'b0);
`ifdef CDB_AGE_PRIO_EN
    cur_head = 5'd6;
    add(1'b0, 1'b0, 4'b0111, {5'd0, 5'd30, 5'd7, 5'd5},
        {6'd0, 6'd40, 6'd17, 6'd15}, 4'b0, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b1010, 1'b1, 5'd7, 6'd17, 1'b0, 2'd1);
    idle(4'b1110, 1'b1, 5'd30, 6'd40, 1'b0, 2'd2);
    idle(4'b1111, 1'b1, 5'd5, 6'd15, 1'b0, 2'd0);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
`else
    // single FU, two-cycle latency
    add(1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd0},
        {6'd0, 6'd0, 6'd10, 6'd0}, 4'b0, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b1111, 1'b1, 5'd3, 6'd10, 1'b0, 2'd1);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    rst_row(1'b0);
    // all four at once from rr_ptr 0
    add(1'b0, 1'b0, 4'b1111, {5'd7, 5'd6, 5'd5, 5'd4},
        {6'd23, 6'd22, 6'd21, 6'd20}, 4'b0100, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b0001, 1'b1, 5'd4, 6'd20, 1'b0, 2'd0);
    idle(4'b0011, 1'b1, 5'd5, 6'd21, 1'b0, 2'd1);
    idle(4'b0111, 1'b1, 5'd6, 6'd22, 1'b1, 2'd2);
    idle(4'b1111, 1'b1, 5'd7, 6'd23, 1'b0, 2'd3);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    // FU2 blocked while holding entry 9
    add(1'b0, 1'b0, 4'b0100, {5'd0, 5'd8, 5'd0, 5'd0},
        {6'd0, 6'd28, 6'd0, 6'd0}, 4'b0, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b1111, 1'b1, 5'd8, 6'd28, 1'b0, 2'd2);
    add(1'b0, 1'b0, 4'b1111, {5'd13, 5'd12, 5'd11, 5'd10},
        {6'd33, 6'd32, 6'd31, 6'd30}, 4'b0, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    add(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0},
        {6'd0, 6'd34, 6'd0, 6'd0}, 4'b0, 4'b1000, 1'b1, 5'd13, 6'd33, 1'b0, 2'd3);
    add(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0},
        {6'd0, 6'd34, 6'd0, 6'd0}, 4'b0, 4'b1001, 1'b1, 5'd10, 6'd30, 1'b0, 2'd0);
    add(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0},
        {6'd0, 6'd34, 6'd0, 6'd0}, 4'b0, 4'b1011, 1'b1, 5'd11, 6'd31, 1'b0, 2'd1);
    add(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0},
        {6'd0, 6'd34, 6'd0, 6'd0}, 4'b0, 4'b1111, 1'b1, 5'd12, 6'd32, 1'b0, 2'd2);
    idle(4'b1111, 1'b1, 5'd9, 6'd34, 1'b0, 2'd2);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    // squash with full slots and a new request
    add(1'b0, 1'b0, 4'b1011, {5'd16, 5'd0, 5'd15, 5'd14},
        {6'd37, 6'd0, 6'd36, 6'd35}, 4'b1000, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    add(1'b0, 1'b1, 4'b0100, {5'd0, 5'd17, 5'd0, 5'd0},
        {6'd0, 6'd38, 6'd0, 6'd0}, 4'b0, 4'b0000, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    // FU0 streams 0..31 then wraps to 0
    for (int k = 0; k <= 32; k++) begin
      logic [4:0] e;
      logic [4:0] pe;
      e  = 5'(k % 32);
      pe = 5'((k + 31) % 32);
      add(1'b0, 1'b0, 4'b0001, {15'd0, e}, {18'd0, 6'(e) + 6'd8},
          {3'd0, (e % 7) == 3}, 4'b1111, k > 0, pe, 6'(pe) + 6'd8,
          (pe % 7) == 3, 2'd0);
    end
    idle(4'b1111, 1'b1, 5'd0, 6'd8, 1'b0, 2'd0);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    // reset and squash together: reset wins
    add(1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd20, 5'd0},
        {6'd0, 6'd0, 6'd40, 6'd0}, 4'b0010, 4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
    rst_row(1'b1);
    idle(4'b1111, 1'b0, 5'd0, 6'd0, 1'b0, 2'd0);
`endif
  endtask

  initial begin
    exp_t e;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    squash = 1'b0;
    fu_valid = '0;
    fu_rob_entry = '0;
    fu_dest_preg = '0;
    fu_mis_pred = '0;
`ifdef CDB_AGE_PRIO_EN
    rob_head = '0;
`endif
    build_table();
    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clock);
      reset        = tbl[n].rst;
      squash       = tbl[n].sq;
      fu_valid     = tbl[n].v;
      fu_rob_entry = tbl[n].rob;
      fu_dest_preg = tbl[n].preg;
      fu_mis_pred  = tbl[n].mis;
`ifdef CDB_AGE_PRIO_EN
      rob_head     = tbl[n].head;
`endif
      e.row = n; e.rst = tbl[n].rst; e.cv = tbl[n].cv;
      e.crob = tbl[n].crob; e.cpreg = tbl[n].cpreg;
      e.cmis = tbl[n].cmis; e.cidx = tbl[n].cidx;
      sb.push_back(e);
      #1;
      if (!tbl[n].rst) chk("fu_ready", n, 32'(fu_ready), 32'(tbl[n].rdy));
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard row %0d: got empty want entry", n);
      end else begin
        e = sb.pop_front();
        chk("cdb_valid", e.row, 32'(cdb_valid), 32'(e.cv));
        if (e.cv || e.rst) begin
          chk("cdb_rob_entry", e.row, 32'(cdb_rob_entry), 32'(e.crob));
          chk("cdb_dest_preg", e.row, 32'(cdb_dest_preg), 32'(e.cpreg));
          chk("cdb_mis_pred", e.row, 32'(cdb_mis_pred), 32'(e.cmis));
          chk("cdb_grant_idx", e.row, 32'(cdb_grant_idx), 32'(e.cidx));
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
